// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: datapath width, fetch step and the
// fetch sequencer state encoding.
package cpu_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, ISSUE} fetch_state_t;

  // Redirect targets are forced onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return {t[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Architectural program counter register; loads `next` on every clock edge.
module program_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] next,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else       pc_q <= next;

  assign pc = pc_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC, issues one imem fetch at a time, hands words
// to decode over valid/ready and applies branch/jump redirects.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int XLEN_P        = XLEN,
  parameter int INSTR_BYTES_P = INSTR_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN_P-1:0] pc,
  output logic              imem_req,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [XLEN_P-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [XLEN_P-1:0] instr,
  output logic [XLEN_P-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [XLEN_P-1:0] redirect_target,
  output logic              misalign_err
);
  fetch_state_t      state_q, state_d;
  logic              flush_q, flush_d;
  logic              req_q, valid_q, misalign_q;
  logic [XLEN_P-1:0] instr_q, instr_pc_q;
  logic [XLEN_P-1:0] pc_next, tgt;
  logic              redir, capture;

  program_counter #(.XLEN(XLEN_P)) u_pc (
    .clk   (clk),
    .reset (reset),
    .next  (pc_next),
    .pc    (pc)
  );

  assign tgt = {redirect_target[XLEN_P-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pc_next = pc;
    capture = 1'b0;
    redir   = redirect_valid && (state_q != BOOT);
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (redir) pc_next = tgt;
        // A request accepted alongside a redirect targets the old pc; its reply must be dropped.
        if (imem_ready) begin
          state_d = WAIT;
          flush_d = redir;
        end
      end
      WAIT: begin
        if (redir) begin
          pc_next = tgt;
          if (imem_rvalid) begin
            flush_d = 1'b0;
            state_d = FETCH;
          end else begin
            flush_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = FETCH;
          end else begin
            capture = 1'b1;
            pc_next = pc + XLEN_P'(INSTR_BYTES_P);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (redir) begin
          pc_next = tgt;
          state_d = FETCH;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      flush_q    <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      req_q      <= (state_d == FETCH);
      valid_q    <= (state_d == ISSUE);
      misalign_q <= misalign_q | (redir && (redirect_target[1:0] != 2'b00));
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural imem plus a scoreboard of expected
// (pc, word) handoffs to decode.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, imem_addr, imem_rdata, instr, instr_pc, redirect_target;
  logic        imem_req, imem_ready, imem_rvalid, instr_valid, instr_ready;
  logic        redirect_valid, misalign_err;

  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0, hs_cnt = 0;
  logic        slow = 1'b0, dly_v = 1'b0;
  logic [31:0] dly_d = '0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.w  = wd(a);
    return e;
  endfunction

  // One clock: imem answers accepted requests after 1 (or 2 when slow) cycles;
  // any decode handshake is checked against the scoreboard.
  task automatic step();
    logic acc, hs;
    logic [31:0] aa, ip, iw;
    exp_t e;
    acc = imem_req && imem_ready;
    aa  = imem_addr;
    hs  = instr_valid && instr_ready;
    ip  = instr_pc;
    iw  = instr;
    @(posedge clk); #1;
    imem_rvalid = dly_v;
    imem_rdata  = dly_d;
    dly_v       = 1'b0;
    if (acc) begin
      if (slow) begin
        dly_v = 1'b1;
        dly_d = wd(aa);
      end else begin
        imem_rvalid = 1'b1;
        imem_rdata  = wd(aa);
      end
    end
    if (hs) begin
      hs_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got pc=%h word=%h want none", ip, iw);
      end else begin
        e = q.pop_front();
        if (ip !== e.pc || iw !== e.w) begin
          errors++;
          $display("FAIL handoff: got pc=%h word=%h want pc=%h word=%h", ip, iw, e.pc, e.w);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step(); step();
    checks++;
    if ({pc, imem_req, instr_valid, misalign_err, instr, instr_pc} !== {32'h0, 3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h req=%b v=%b mis=%b instr=%h ipc=%h want all zero",
               pc, imem_req, instr_valid, misalign_err, instr, instr_pc);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_to_fetch: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(mk(32'(4 * i)));
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (imem_req !== (i % 3 == 0) || (i % 3 == 0 && imem_addr !== 32'(4 * (i / 3)))) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: got req=%b addr=%h want req=%b addr=%h",
                 i, imem_req, imem_addr, (i % 3 == 0), 32'(4 * (i / 3)));
      end
      step();
    end
    checks++;
    if (pc !== 32'hC || q.size() != 0) begin
      errors++;
      $display("FAIL seq_end: got pc=%h pending=%0d want 0000000c 0", pc, q.size());
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== wd(32'hC) || instr_pc !== 32'hC ||
          pc !== 32'h10 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b instr=%h ipc=%h pc=%h req=%b want 1 %h 0000000c 00000010 0",
                 i, instr_valid, instr, instr_pc, pc, imem_req, wd(32'hC));
      end
      step();
    end
    q.push_back(mk(32'hC));
    instr_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h want 1 00000010", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    slow = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h2C;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (pc !== 32'h2C || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_pc: got pc=%h v=%b want 0000002c 0", pc, instr_valid);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2C || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_flush: got req=%b addr=%h v=%b want 1 0000002c 0",
               imem_req, imem_addr, instr_valid);
    end
    slow = 1'b0;
    q.push_back(mk(32'h2C));
    step(); step(); step();
    checks++;
    if (pc !== 32'h30 || q.size() != 0) begin
      errors++;
      $display("FAIL redir_wait_refetch: got pc=%h pending=%0d want 00000030 0", pc, q.size());
    end
  endtask

  task automatic test_redirect_issue();
    int h0;
    instr_ready = 1'b0;
    step(); step();
    q.push_back(mk(32'h30));
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || q.size() != 0) begin
      errors++;
      $display("FAIL redir_issue_consumed: got req=%b addr=%h pending=%0d want 1 00000040 0",
               imem_req, imem_addr, q.size());
    end
    instr_ready = 1'b0;
    step(); step();
    h0 = hs_cnt;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (hs_cnt != h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_issue_dropped: got hs=%0d v=%b req=%b addr=%h want %0d 0 1 00000040",
               hs_cnt, instr_valid, imem_req, imem_addr, h0);
    end
    instr_ready = 1'b1;
  endtask

  task automatic test_misalign_wrap();
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h13;
    step();
    checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL misalign: got mis=%b req=%b addr=%h want 1 1 00000010",
               misalign_err, imem_req, imem_addr);
    end
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL misalign_sticky: got mis=%b addr=%h want 1 fffffffc", misalign_err, imem_addr);
    end
    imem_ready = 1'b1;
    q.push_back(mk(32'hFFFF_FFFC));
    step(); step(); step();
    checks++;
    if (pc !== 32'h0 || q.size() != 0) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h pending=%0d want 00000000 0", pc, q.size());
    end
    // redirect coinciding with an accepted fetch: old-pc reply must vanish
    redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (pc !== 32'h80 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_fetch_acc: got pc=%h req=%b want 00000080 0", pc, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_fetch_flush: got req=%b addr=%h v=%b want 1 00000080 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    slow = 1'b1;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0 ||
        instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got pc=%h req=%b v=%b mis=%b ipc=%h want 0 0 0 0 0",
               pc, imem_req, instr_valid, misalign_err, instr_pc);
    end
    dly_v = 1'b0; imem_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: got req=%b addr=%h v=%b want 1 00000000 0",
               imem_req, imem_addr, instr_valid);
    end
    slow = 1'b0; imem_ready = 1'b1;
    q.push_back(mk(32'h0));
    step(); step(); step();
    checks++;
    if (pc !== 32'h4 || q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_fetch: got pc=%h pending=%0d want 00000004 0", pc, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_issue();
    test_misalign_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
